// File: rtl/csi2_rx_pkg.sv
// Shared definitions for the CSI-2 video frame guard.
//   guard_state_t     : frame-tracking state machine encoding
//   DEFAULT_CNT_WIDTH : default width of the line/pixel geometry counters
package csi2_rx_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,  // dropping beats until an enabled start of frame
    PASS     = 2'd1,  // forwarding a frame, new frames admitted
    DRAIN    = 2'd2   // forwarding the current frame only, then stop
  } guard_state_t;

  localparam int DEFAULT_CNT_WIDTH = 16;

endpackage

// File: rtl/csi2_frame_fifo.sv
// Synchronous FIFO with a registered output stage.
// Storage is an inferred RAM with registered read; the read register doubles
// as the output holding register, so the total capacity (RAM + output
// register) is exactly DEPTH entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : write wr_data (caller guarantees !full)
//   full       : registered-state full flag, independent of rd_en
//   rd_en      : pop the current output entry (ignored when !rd_valid)
//   rd_valid   : rd_data holds a valid entry
module csi2_frame_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW1 = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW1-1:0]   mem_cnt_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             pop;
  logic             load;
  logic [CW1-1:0]   total_cnt;

  assign pop  = rd_en && out_valid_reg;
  // Refill the output register whenever it is empty or being consumed.
  assign load = (mem_cnt_reg != '0) && (!out_valid_reg || pop);

  assign total_cnt = mem_cnt_reg + CW1'(out_valid_reg);
  // Full is derived from registered counts only, so a pop in the same cycle
  // never reopens the write side.
  assign full = (total_cnt == CW1'(DEPTH));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      mem_cnt_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (load) begin
        out_data_reg  <= mem[rd_ptr_reg];
        rd_ptr_reg    <= rd_ptr_reg + AW'(1);
        out_valid_reg <= 1'b1;
      end else if (pop) begin
        out_valid_reg <= 1'b0;
      end
      mem_cnt_reg <= mem_cnt_reg + CW1'(wr_en) - CW1'(load);
    end
  end

  assign rd_valid = out_valid_reg;
  assign rd_data  = out_data_reg;

endmodule

// File: rtl/csi2_video_frame_guard.sv
// CSI-2 video frame guard.
// Admits whole frames from an AXI4-Stream video source, checks line length
// and frame height against the programmed geometry, and buffers the accepted
// beats in an output FIFO.
//   px_clk_i, px_arstn_i     : pixel clock, asynchronous active-low reset
//   enable_i                 : admit new frames
//   px_per_line_i            : expected beats per line (0 disables the check)
//   lines_per_frame_i        : expected lines per frame (0: frame never ends)
//   s_t*_i / s_tready_o      : input stream (tuser = start of frame)
//   m_t*_o / m_tready_i      : output stream, same sideband layout
//   frame_done_o             : pulse when a complete frame has been accepted
//   line_err_o               : pulse after a line with the wrong length
//   frame_err_o              : pulse on an early start of frame
//   frame_cnt_o              : completed frame count, wraps
module csi2_video_frame_guard
  import csi2_rx_pkg::*;
#(
  parameter int TDATA_WIDTH = 16,
  parameter int ID_WIDTH    = 1,
  parameter int DEST_WIDTH  = 1,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
  input  logic                     px_clk_i,
  input  logic                     px_arstn_i,
  input  logic                     enable_i,
  input  logic [CNT_WIDTH-1:0]     px_per_line_i,
  input  logic [CNT_WIDTH-1:0]     lines_per_frame_i,
  input  logic [TDATA_WIDTH-1:0]   s_tdata_i,
  input  logic [TDATA_WIDTH/8-1:0] s_tstrb_i,
  input  logic [TDATA_WIDTH/8-1:0] s_tkeep_i,
  input  logic                     s_tuser_i,
  input  logic [ID_WIDTH-1:0]      s_tid_i,
  input  logic [DEST_WIDTH-1:0]    s_tdest_i,
  input  logic                     s_tlast_i,
  input  logic                     s_tvalid_i,
  output logic                     s_tready_o,
  output logic [TDATA_WIDTH-1:0]   m_tdata_o,
  output logic [TDATA_WIDTH/8-1:0] m_tstrb_o,
  output logic [TDATA_WIDTH/8-1:0] m_tkeep_o,
  output logic                     m_tuser_o,
  output logic [ID_WIDTH-1:0]      m_tid_o,
  output logic [DEST_WIDTH-1:0]    m_tdest_o,
  output logic                     m_tlast_o,
  output logic                     m_tvalid_o,
  input  logic                     m_tready_i,
  output logic                     frame_done_o,
  output logic                     line_err_o,
  output logic                     frame_err_o,
  output logic [31:0]              frame_cnt_o
);

  localparam int KW = TDATA_WIDTH / 8;
  localparam int PW = TDATA_WIDTH + 2 * KW + 1 + ID_WIDTH + DEST_WIDTH + 1;

  guard_state_t         state_reg, state_next;
  logic [CNT_WIDTH-1:0] px_reg, px_next;
  logic [CNT_WIDTH-1:0] line_reg, line_next;
  logic [CNT_WIDTH-1:0] ppl_reg, ppl_next;
  logic [CNT_WIDTH-1:0] lpf_reg, lpf_next;
  logic [31:0]          frame_cnt_reg, frame_cnt_next;
  logic                 line_err_reg, line_err_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 frame_done_reg, frame_done_next;
  logic                 ready_en_reg;

  logic                 fifo_full;
  logic                 fifo_wr;
  logic [PW-1:0]        fifo_wr_data;
  logic [PW-1:0]        fifo_rd_data;
  logic                 s_accept;
  logic                 start_frame;
  logic                 process_beat;
  logic [CNT_WIDTH-1:0] cur_px, cur_line, cur_ppl, cur_lpf;
  logic [CNT_WIDTH-1:0] px_inc, line_inc;

  // ready_en_reg holds s_tready_o low for the first cycle after reset release.
  // Full blocks the input in every state so a start of frame arriving while
  // the previous frame is still buffered cannot overflow the FIFO.
  assign s_tready_o = ready_en_reg && !fifo_full;
  assign s_accept   = s_tvalid_i && s_tready_o;

  assign fifo_wr_data = {s_tdata_i, s_tstrb_i, s_tkeep_i, s_tuser_i,
                         s_tid_i, s_tdest_i, s_tlast_i};
  assign {m_tdata_o, m_tstrb_o, m_tkeep_o, m_tuser_o,
          m_tid_o, m_tdest_o, m_tlast_o} = fifo_rd_data;

  csi2_frame_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (px_clk_i),
    .rst_n    (px_arstn_i),
    .wr_en    (fifo_wr),
    .wr_data  (fifo_wr_data),
    .full     (fifo_full),
    .rd_en    (m_tready_i),
    .rd_valid (m_tvalid_o),
    .rd_data  (fifo_rd_data)
  );

  always_ff @(posedge px_clk_i or negedge px_arstn_i) begin
    if (!px_arstn_i) begin
      state_reg      <= WAIT_SOF;
      px_reg         <= '0;
      line_reg       <= '0;
      ppl_reg        <= '0;
      lpf_reg        <= '0;
      frame_cnt_reg  <= '0;
      line_err_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      ready_en_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      px_reg         <= px_next;
      line_reg       <= line_next;
      ppl_reg        <= ppl_next;
      lpf_reg        <= lpf_next;
      frame_cnt_reg  <= frame_cnt_next;
      line_err_reg   <= line_err_next;
      frame_err_reg  <= frame_err_next;
      frame_done_reg <= frame_done_next;
      ready_en_reg   <= 1'b1;
    end
  end

  always_comb begin
    state_next      = state_reg;
    px_next         = px_reg;
    line_next       = line_reg;
    ppl_next        = ppl_reg;
    lpf_next        = lpf_reg;
    frame_cnt_next  = frame_cnt_reg;
    line_err_next   = 1'b0;
    frame_err_next  = 1'b0;
    frame_done_next = 1'b0;
    fifo_wr         = 1'b0;
    start_frame     = 1'b0;
    process_beat    = 1'b0;

    case (state_reg)
      WAIT_SOF: begin
        if (s_accept && s_tuser_i && enable_i) begin
          state_next   = PASS;
          start_frame  = 1'b1;
          process_beat = 1'b1;
        end
      end
      PASS: begin
        if (!enable_i) begin
          state_next = DRAIN;
        end
        if (s_accept) begin
          process_beat = 1'b1;
          // Early start of frame: restart geometry from this beat.
          if (s_tuser_i) begin
            frame_err_next = 1'b1;
            start_frame    = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (s_accept) begin
          if (s_tuser_i) begin
            frame_err_next = 1'b1;
            state_next     = WAIT_SOF;
          end else begin
            process_beat = 1'b1;
          end
        end
      end
      default: state_next = WAIT_SOF;
    endcase

    // Geometry for this beat: a start-of-frame beat uses freshly sampled
    // inputs and zeroed counters; other beats use the held frame values.
    cur_px   = start_frame ? '0 : px_reg;
    cur_line = start_frame ? '0 : line_reg;
    cur_ppl  = start_frame ? px_per_line_i : ppl_reg;
    cur_lpf  = start_frame ? lines_per_frame_i : lpf_reg;
    px_inc   = cur_px + CNT_WIDTH'(1);
    line_inc = cur_line + CNT_WIDTH'(1);
    if (start_frame) begin
      ppl_next = px_per_line_i;
      lpf_next = lines_per_frame_i;
    end

    if (process_beat) begin
      fifo_wr = 1'b1;
      if (s_tlast_i) begin
        line_err_next = (cur_ppl != '0) && (px_inc != cur_ppl);
        px_next       = '0;
        line_next     = line_inc;
        // End of frame overrides a pending PASS->DRAIN transition.
        if ((cur_lpf != '0) && (line_inc == cur_lpf)) begin
          frame_done_next = 1'b1;
          frame_cnt_next  = frame_cnt_reg + 32'd1;
          state_next      = WAIT_SOF;
        end
      end else begin
        px_next   = px_inc;
        line_next = cur_line;
      end
    end
  end

  assign frame_done_o = frame_done_reg;
  assign line_err_o   = line_err_reg;
  assign frame_err_o  = frame_err_reg;
  assign frame_cnt_o  = frame_cnt_reg;

endmodule

// File: tb/tb_csi2_video_frame_guard.sv
module tb_csi2_video_frame_guard;

  logic        px_clk_i = 1'b0;
  logic        px_arstn_i;
  logic        enable_i;
  logic [15:0] px_per_line_i;
  logic [15:0] lines_per_frame_i;
  logic [15:0] s_tdata_i;
  logic [1:0]  s_tstrb_i;
  logic [1:0]  s_tkeep_i;
  logic        s_tuser_i;
  logic [0:0]  s_tid_i;
  logic [0:0]  s_tdest_i;
  logic        s_tlast_i;
  logic        s_tvalid_i;
  logic        s_tready_o;
  logic [15:0] m_tdata_o;
  logic [1:0]  m_tstrb_o;
  logic [1:0]  m_tkeep_o;
  logic        m_tuser_o;
  logic [0:0]  m_tid_o;
  logic [0:0]  m_tdest_o;
  logic        m_tlast_o;
  logic        m_tvalid_o;
  logic        m_tready_i;
  logic        frame_done_o;
  logic        line_err_o;
  logic        frame_err_o;
  logic [31:0] frame_cnt_o;

  always #5 px_clk_i = ~px_clk_i;

  csi2_video_frame_guard #(
    .TDATA_WIDTH (16),
    .ID_WIDTH    (1),
    .DEST_WIDTH  (1),
    .FIFO_DEPTH  (16),
    .CNT_WIDTH   (16)
  ) dut (
    .px_clk_i          (px_clk_i),
    .px_arstn_i        (px_arstn_i),
    .enable_i          (enable_i),
    .px_per_line_i     (px_per_line_i),
    .lines_per_frame_i (lines_per_frame_i),
    .s_tdata_i         (s_tdata_i),
    .s_tstrb_i         (s_tstrb_i),
    .s_tkeep_i         (s_tkeep_i),
    .s_tuser_i         (s_tuser_i),
    .s_tid_i           (s_tid_i),
    .s_tdest_i         (s_tdest_i),
    .s_tlast_i         (s_tlast_i),
    .s_tvalid_i        (s_tvalid_i),
    .s_tready_o        (s_tready_o),
    .m_tdata_o         (m_tdata_o),
    .m_tstrb_o         (m_tstrb_o),
    .m_tkeep_o         (m_tkeep_o),
    .m_tuser_o         (m_tuser_o),
    .m_tid_o           (m_tid_o),
    .m_tdest_o         (m_tdest_o),
    .m_tlast_o         (m_tlast_o),
    .m_tvalid_o        (m_tvalid_o),
    .m_tready_i        (m_tready_i),
    .frame_done_o      (frame_done_o),
    .line_err_o        (line_err_o),
    .frame_err_o       (frame_err_o),
    .frame_cnt_o       (frame_cnt_o)
  );

  int checks = 0;
  int passed = 0;

  // Output beat log and event counters, sampled on the falling edge.
  logic [23:0] out_mem [0:4095];
  int out_n  = 0;
  int in_acc = 0;
  int n_le   = 0;
  int n_fe   = 0;
  int n_fd   = 0;
  int cyc    = 0;

  always @(negedge px_clk_i) begin
    if (m_tvalid_o && m_tready_i) begin
      out_mem[out_n % 4096] <= {m_tdest_o, m_tid_o, m_tkeep_o, m_tstrb_o,
                                m_tuser_o, m_tlast_o, m_tdata_o};
      out_n <= out_n + 1;
    end
    if (s_tvalid_i && s_tready_o) in_acc <= in_acc + 1;
    if (line_err_o)   n_le <= n_le + 1;
    if (frame_err_o)  n_fe <= n_fe + 1;
    if (frame_done_o) n_fd <= n_fd + 1;
  end

  always @(posedge px_clk_i) cyc <= cyc + 1;

  logic [23:0] exp_q [$];
  int out_rd   = 0;
  int data_ctr = 0;
  bit stuck    = 1'b0;

  function automatic logic [23:0] pack(input logic [15:0] d, input logic u, input logic l);
    return {d[3], d[2], ~d[1:0], d[1:0], u, l, d};
  endfunction

  // Drive n beats back to back; sideband fields are derived from the data.
  task automatic send_line(input int n, input bit sof, input bit eol, input bit keep, input int en_drop_at);
    for (int i = 0; i < n; i++) begin
      logic [15:0] d;
      int guard;
      d = data_ctr[15:0];
      data_ctr++;
      if (i == en_drop_at) enable_i = 1'b0;
      s_tdata_i  = d;
      s_tuser_i  = sof && (i == 0);
      s_tlast_i  = eol && (i == n - 1);
      s_tstrb_i  = d[1:0];
      s_tkeep_i  = ~d[1:0];
      s_tid_i    = d[2];
      s_tdest_i  = d[3];
      s_tvalid_i = 1'b1;
      if (keep) exp_q.push_back(pack(d, s_tuser_i, s_tlast_i));
      guard = 0;
      while (!stuck) begin
        @(negedge px_clk_i);
        if (s_tready_o === 1'b1) begin
          @(posedge px_clk_i);
          #1;
          break;
        end
        guard++;
        if (guard > 200) begin
          checks++;
          $display("FAIL send_timeout: s_tready_o=%b for 200 cycles, required 1", s_tready_o);
          stuck = 1'b1;
        end
      end
    end
    s_tvalid_i = 1'b0;
    s_tuser_i  = 1'b0;
    s_tlast_i  = 1'b0;
  endtask

  task automatic send_frame(input int lines, input int ppl, input bit keep);
    for (int l = 0; l < lines; l++) send_line(ppl, l == 0, 1'b1, keep, -1);
  endtask

  // Wait (bounded) for the expected beats, then report how many arrived and
  // how many differ from the expected sequence.
  task automatic collect(output int got, output int bad, output logic [23:0] act, output logic [23:0] expv);
    int need;
    int guard;
    need  = exp_q.size();
    guard = 0;
    while ((out_n - out_rd) < need && guard < 400) begin
      @(posedge px_clk_i);
      guard++;
    end
    repeat (6) @(posedge px_clk_i);
    #1;
    got  = out_n - out_rd;
    bad  = 0;
    act  = '0;
    expv = '0;
    for (int i = 0; i < need && i < got; i++) begin
      int idx;
      idx = (out_rd + i) % 4096;
      if (out_mem[idx] !== exp_q[i]) begin
        if (bad == 0) begin
          act  = out_mem[idx];
          expv = exp_q[i];
        end
        bad++;
      end
    end
    out_rd = out_n;
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge px_clk_i);
    @(negedge px_clk_i);
    checks++; if (s_tready_o !== 1'b0) $display("FAIL reset_tready: got %b required 0", s_tready_o); else passed++;
    checks++; if (m_tvalid_o !== 1'b0) $display("FAIL reset_tvalid: got %b required 0", m_tvalid_o); else passed++;
    checks++; if (frame_cnt_o !== 32'd0) $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt_o); else passed++;
    checks++; if ({line_err_o, frame_err_o, frame_done_o} !== 3'b000) $display("FAIL reset_pulses: got %b required 000", {line_err_o, frame_err_o, frame_done_o}); else passed++;
    @(posedge px_clk_i);
    #1 px_arstn_i = 1'b1;
    @(negedge px_clk_i);
    checks++; if (s_tready_o !== 1'b0) $display("FAIL release_tready_early: got %b required 0", s_tready_o); else passed++;
    @(negedge px_clk_i);
    checks++; if (s_tready_o !== 1'b1) $display("FAIL release_tready: got %b required 1", s_tready_o); else passed++;
    $display("test_reset: done");
    @(posedge px_clk_i);
    #1;
  endtask

  task automatic test_clean_frame();
    int got, bad, le0, fe0, fd0;
    logic [23:0] a, e;
    le0 = n_le; fe0 = n_fe; fd0 = n_fd;
    send_frame(4, 8, 1'b1);
    collect(got, bad, a, e);
    checks++; if (got !== 32) $display("FAIL clean_count: got %0d beats required 32", got); else passed++;
    checks++; if (bad !== 0) $display("FAIL clean_data: %0d bad, first got %h required %h", bad, a, e); else passed++;
    checks++; if (n_fd - fd0 !== 1) $display("FAIL clean_done: got %0d pulses required 1", n_fd - fd0); else passed++;
    checks++; if (frame_cnt_o !== 32'd1) $display("FAIL clean_frame_cnt: got %0d required 1", frame_cnt_o); else passed++;
    checks++; if ((n_le - le0) + (n_fe - fe0) !== 0) $display("FAIL clean_errs: got %0d error pulses required 0", (n_le - le0) + (n_fe - fe0)); else passed++;
    $display("test_clean_frame: %0d beats out", got);
  endtask

  task automatic test_mid_frame_start();
    int got, bad, le0, fe0, fd0;
    logic [23:0] a, e;
    // Part of a frame is left in the stalled FIFO, then reset discards it.
    m_tready_i = 1'b0;
    send_line(5, 1'b1, 1'b0, 1'b0, -1);
    @(posedge px_clk_i);
    #1 px_arstn_i = 1'b0;
    @(negedge px_clk_i);
    checks++; if (m_tvalid_o !== 1'b0) $display("FAIL midreset_tvalid: got %b required 0", m_tvalid_o); else passed++;
    checks++; if (frame_cnt_o !== 32'd0) $display("FAIL midreset_frame_cnt: got %0d required 0", frame_cnt_o); else passed++;
    @(posedge px_clk_i);
    #1 px_arstn_i = 1'b1;
    m_tready_i = 1'b1;
    @(posedge px_clk_i);
    #1;
    out_rd = out_n;
    le0 = n_le; fe0 = n_fe; fd0 = n_fd;
    send_line(8, 1'b0, 1'b1, 1'b0, -1);
    send_line(8, 1'b0, 1'b1, 1'b0, -1);
    send_frame(4, 8, 1'b1);
    collect(got, bad, a, e);
    checks++; if (got !== 32) $display("FAIL mid_count: got %0d beats required 32", got); else passed++;
    checks++; if (bad !== 0) $display("FAIL mid_data: %0d bad, first got %h required %h", bad, a, e); else passed++;
    checks++; if (n_fd - fd0 !== 1) $display("FAIL mid_done: got %0d pulses required 1", n_fd - fd0); else passed++;
    checks++; if (frame_cnt_o !== 32'd1) $display("FAIL mid_frame_cnt: got %0d required 1", frame_cnt_o); else passed++;
    checks++; if ((n_le - le0) + (n_fe - fe0) !== 0) $display("FAIL mid_errs: got %0d error pulses required 0", (n_le - le0) + (n_fe - fe0)); else passed++;
    $display("test_mid_frame_start: %0d beats out", got);
  endtask

  task automatic test_short_line();
    int got, bad, le0, fe0, fd0;
    logic [23:0] a, e;
    le0 = n_le; fe0 = n_fe; fd0 = n_fd;
    send_line(8, 1'b1, 1'b1, 1'b1, -1);
    send_line(7, 1'b0, 1'b1, 1'b1, -1);
    send_line(8, 1'b0, 1'b1, 1'b1, -1);
    send_line(8, 1'b0, 1'b1, 1'b1, -1);
    collect(got, bad, a, e);
    checks++; if (got !== 31) $display("FAIL short_count: got %0d beats required 31", got); else passed++;
    checks++; if (bad !== 0) $display("FAIL short_data: %0d bad, first got %h required %h", bad, a, e); else passed++;
    checks++; if (n_le - le0 !== 1) $display("FAIL short_line_err: got %0d pulses required 1", n_le - le0); else passed++;
    checks++; if (n_fd - fd0 !== 1) $display("FAIL short_done: got %0d pulses required 1", n_fd - fd0); else passed++;
    checks++; if (frame_cnt_o !== 32'd2) $display("FAIL short_frame_cnt: got %0d required 2", frame_cnt_o); else passed++;
    checks++; if (n_fe - fe0 !== 0) $display("FAIL short_frame_err: got %0d pulses required 0", n_fe - fe0); else passed++;
    $display("test_short_line: %0d beats out", got);
  endtask

  task automatic test_early_sof();
    int got, bad, le0, fe0, fd0;
    logic [23:0] a, e;
    le0 = n_le; fe0 = n_fe; fd0 = n_fd;
    send_line(8, 1'b1, 1'b1, 1'b1, -1);
    send_line(8, 1'b0, 1'b1, 1'b1, -1);
    send_line(2, 1'b0, 1'b0, 1'b1, -1);
    send_frame(4, 8, 1'b1);
    collect(got, bad, a, e);
    checks++; if (got !== 50) $display("FAIL early_count: got %0d beats required 50", got); else passed++;
    checks++; if (bad !== 0) $display("FAIL early_data: %0d bad, first got %h required %h", bad, a, e); else passed++;
    checks++; if (n_fe - fe0 !== 1) $display("FAIL early_frame_err: got %0d pulses required 1", n_fe - fe0); else passed++;
    checks++; if (n_fd - fd0 !== 1) $display("FAIL early_done: got %0d pulses required 1", n_fd - fd0); else passed++;
    checks++; if (frame_cnt_o !== 32'd3) $display("FAIL early_frame_cnt: got %0d required 3", frame_cnt_o); else passed++;
    checks++; if (n_le - le0 !== 0) $display("FAIL early_line_err: got %0d pulses required 0", n_le - le0); else passed++;
    $display("test_early_sof: %0d beats out", got);
  endtask

  task automatic test_backpressure();
    int got, bad, fd0, in0, unstable;
    logic [23:0] a, e, snap, cur;
    bit have;
    bit tv_end, tr_end;
    int acc_end;
    fd0 = n_fd; in0 = in_acc; unstable = 0; have = 1'b0; snap = '0;
    m_tready_i = 1'b0;
    fork
      send_frame(4, 8, 1'b1);
      begin
        repeat (40) begin
          @(negedge px_clk_i);
          cur = {m_tdest_o, m_tid_o, m_tkeep_o, m_tstrb_o, m_tuser_o, m_tlast_o, m_tdata_o};
          if (m_tvalid_o) begin
            if (!have) begin
              snap = cur;
              have = 1'b1;
            end else if (cur !== snap) begin
              unstable++;
            end
          end else if (have) begin
            unstable++;
          end
        end
        @(posedge px_clk_i);
        #1;
        acc_end = in_acc - in0;
        tr_end  = s_tready_o;
        tv_end  = m_tvalid_o;
        m_tready_i = 1'b1;
      end
    join
    checks++; if (acc_end !== 16) $display("FAIL bp_accepted: got %0d beats required 16", acc_end); else passed++;
    checks++; if (tr_end !== 1'b0) $display("FAIL bp_tready: got %b required 0", tr_end); else passed++;
    checks++; if (tv_end !== 1'b1) $display("FAIL bp_tvalid: got %b required 1", tv_end); else passed++;
    checks++; if (unstable !== 0) $display("FAIL bp_stable: got %0d changes required 0", unstable); else passed++;
    collect(got, bad, a, e);
    checks++; if (got !== 32) $display("FAIL bp_count: got %0d beats required 32", got); else passed++;
    checks++; if (bad !== 0) $display("FAIL bp_data: %0d bad, first got %h required %h", bad, a, e); else passed++;
    checks++; if (n_fd - fd0 !== 1) $display("FAIL bp_done: got %0d pulses required 1", n_fd - fd0); else passed++;
    $display("test_backpressure: %0d beats out", got);
  endtask

  task automatic test_enable_drop();
    int got, bad, le0, fe0, fd0;
    logic [23:0] a, e;
    le0 = n_le; fe0 = n_fe; fd0 = n_fd;
    send_line(8, 1'b1, 1'b1, 1'b1, -1);
    send_line(8, 1'b0, 1'b1, 1'b1, 2);
    send_line(8, 1'b0, 1'b1, 1'b1, -1);
    send_line(8, 1'b0, 1'b1, 1'b1, -1);
    send_frame(4, 8, 1'b0);
    enable_i = 1'b1;
    send_frame(4, 8, 1'b1);
    collect(got, bad, a, e);
    checks++; if (got !== 64) $display("FAIL en_count: got %0d beats required 64", got); else passed++;
    checks++; if (bad !== 0) $display("FAIL en_data: %0d bad, first got %h required %h", bad, a, e); else passed++;
    checks++; if (n_fd - fd0 !== 2) $display("FAIL en_done: got %0d pulses required 2", n_fd - fd0); else passed++;
    checks++; if (frame_cnt_o !== 32'd6) $display("FAIL en_frame_cnt: got %0d required 6", frame_cnt_o); else passed++;
    checks++; if ((n_le - le0) + (n_fe - fe0) !== 0) $display("FAIL en_errs: got %0d error pulses required 0", (n_le - le0) + (n_fe - fe0)); else passed++;
    $display("test_enable_drop: %0d beats out", got);
  endtask

  task automatic test_back_to_back();
    int got, bad, fd0, c0, dc;
    logic [23:0] a, e;
    fd0 = n_fd;
    c0 = cyc;
    send_frame(4, 8, 1'b1);
    send_frame(4, 8, 1'b1);
    dc = cyc - c0;
    collect(got, bad, a, e);
    checks++; if (dc !== 64) $display("FAIL b2b_cycles: got %0d cycles required 64", dc); else passed++;
    checks++; if (got !== 64) $display("FAIL b2b_count: got %0d beats required 64", got); else passed++;
    checks++; if (bad !== 0) $display("FAIL b2b_data: %0d bad, first got %h required %h", bad, a, e); else passed++;
    checks++; if (n_fd - fd0 !== 2) $display("FAIL b2b_done: got %0d pulses required 2", n_fd - fd0); else passed++;
    checks++; if (frame_cnt_o !== 32'd8) $display("FAIL b2b_frame_cnt: got %0d required 8", frame_cnt_o); else passed++;
    $display("test_back_to_back: %0d beats in %0d cycles", got, dc);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    px_arstn_i        = 1'b0;
    enable_i          = 1'b1;
    px_per_line_i     = 16'd8;
    lines_per_frame_i = 16'd4;
    s_tdata_i         = '0;
    s_tstrb_i         = '0;
    s_tkeep_i         = '0;
    s_tuser_i         = 1'b0;
    s_tid_i           = '0;
    s_tdest_i         = '0;
    s_tlast_i         = 1'b0;
    s_tvalid_i        = 1'b0;
    m_tready_i        = 1'b1;
    test_reset();
    test_clean_frame();
    test_mid_frame_start();
    test_short_line();
    test_early_sof();
    test_backpressure();
    test_enable_drop();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
